// File: rtl/hc_combined_enc_dec.sv
// Hamming(7,4) encode -> optional single-bit fault -> decode/correct, as a two-stage pipeline.
// Codeword bit k (1..7) is stored at index k so position numbers and syndromes line up directly.
module hc_combined_enc_dec (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_data,
    input  logic       i_inj_en,
    input  logic [2:0] i_inj_pos,
    output logic [6:0] o_codeword,
    output logic [2:0] o_syndrome,
    output logic [4:1] o_dec_data,
    output logic       o_err_flag
);

    logic [7:1] code;
    logic [7:1] flip_mask;
    logic [7:1] rx;
    logic [7:1] fixed;
    logic [2:0] syn;
    logic [4:1] dec;

    // Even-parity encode: data at 3,5,6,7; parity at the power-of-two positions
    always_comb begin
        code    = '0;
        code[3] = i_data[0];
        code[5] = i_data[1];
        code[6] = i_data[2];
        code[7] = i_data[3];
        code[1] = code[3] ^ code[5] ^ code[7];
        code[2] = code[3] ^ code[6] ^ code[7];
        code[4] = code[5] ^ code[6] ^ code[7];
    end

    always_comb begin
        flip_mask = '0;
        for (int k = 1; k <= 7; k++) begin
            if (i_inj_en && (i_inj_pos == 3'(k))) begin
                flip_mask[k] = 1'b1;
            end
        end
    end

    // Stage 1: the clean codeword is exposed, the possibly-faulted copy feeds the decoder
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_codeword <= '0;
            rx         <= '0;
        end else begin
            o_codeword <= code;
            rx         <= code ^ flip_mask;
        end
    end

    // The syndrome is the position of the single flipped bit, or 0 when clean
    always_comb begin
        syn[0] = rx[1] ^ rx[3] ^ rx[5] ^ rx[7];
        syn[1] = rx[2] ^ rx[3] ^ rx[6] ^ rx[7];
        syn[2] = rx[4] ^ rx[5] ^ rx[6] ^ rx[7];
        fixed  = rx;
        for (int k = 1; k <= 7; k++) begin
            if (syn == 3'(k)) begin
                fixed[k] = ~rx[k];
            end
        end
        dec = {fixed[7], fixed[6], fixed[5], fixed[3]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_syndrome <= '0;
            o_dec_data <= '0;
            o_err_flag <= 1'b0;
        end else begin
            o_syndrome <= syn;
            o_dec_data <= dec;
            o_err_flag <= (syn != 3'd0);
        end
    end

endmodule

// File: tb/tb_hc_combined_enc_dec.sv
// Directed-vector bench for hc_combined_enc_dec: reset, table of single vectors,
// a back-to-back sweep of every data/fault combination, and a mid-stream reset.
module tb_hc_combined_enc_dec;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_data;
    logic       i_inj_en;
    logic [2:0] i_inj_pos;
    logic [6:0] o_codeword;
    logic [2:0] o_syndrome;
    logic [4:1] o_dec_data;
    logic       o_err_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] data;
        logic       en;
        logic [2:0] pos;
        logic [6:0] cw;
        logic [3:0] dec;
        logic [2:0] syn;
        logic       err;
    } vec_t;

    vec_t vecs [10];
    logic [6:0] cw_tab [16];

    hc_combined_enc_dec dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_inj_en   (i_inj_en),
        .i_inj_pos  (i_inj_pos),
        .o_codeword (o_codeword),
        .o_syndrome (o_syndrome),
        .o_dec_data (o_dec_data),
        .o_err_flag (o_err_flag)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic en, input logic [2:0] pos);
        i_data    = d;
        i_inj_en  = en;
        i_inj_pos = pos;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cw"},  o_codeword, 7'h00);
        checkOutput({tag, "_syn"}, 7'(o_syndrome), 7'h00);
        checkOutput({tag, "_dec"}, 7'(o_dec_data), 7'h00);
        checkOutput({tag, "_err"}, 7'(o_err_flag), 7'h00);
    endtask

    initial begin
        logic [3:0] prev_data;
        logic [2:0] prev_pos;
        int         since;
        logic [3:0] cur_data;
        logic [2:0] cur_pos;

        // Hand-computed codewords c[7:1] for every data value
        cw_tab = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                   7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

        vecs[0] = '{4'h0, 1'b0, 3'd0, 7'h00, 4'h0, 3'd0, 1'b0};
        vecs[1] = '{4'h1, 1'b0, 3'd0, 7'h07, 4'h1, 3'd0, 1'b0};
        vecs[2] = '{4'hF, 1'b0, 3'd0, 7'h7F, 4'hF, 3'd0, 1'b0};
        vecs[3] = '{4'hA, 1'b0, 3'd0, 7'h52, 4'hA, 3'd0, 1'b0};
        vecs[4] = '{4'hA, 1'b1, 3'd5, 7'h52, 4'hA, 3'd5, 1'b1};
        vecs[5] = '{4'hA, 1'b1, 3'd0, 7'h52, 4'hA, 3'd0, 1'b0};
        vecs[6] = '{4'h6, 1'b0, 3'd3, 7'h33, 4'h6, 3'd0, 1'b0};
        vecs[7] = '{4'h9, 1'b1, 3'd1, 7'h4C, 4'h9, 3'd1, 1'b1};
        vecs[8] = '{4'h9, 1'b1, 3'd4, 7'h4C, 4'h9, 3'd4, 1'b1};
        vecs[9] = '{4'hC, 1'b1, 3'd7, 7'h61, 4'hC, 3'd7, 1'b1};

        // Reset held, then released with zero input
        i_rst = 1'b1;
        applyStimulus(4'h0, 1'b0, 3'd0);
        repeat (3) @(posedge i_clk);
        #1;
        checkAllZero("rst_hold");
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checkAllZero("rst_release");

        // Single vectors held for two edges so both stages settle
        for (int v = 0; v < 10; v++) begin
            @(negedge i_clk);
            applyStimulus(vecs[v].data, vecs[v].en, vecs[v].pos);
            repeat (2) @(posedge i_clk);
            #1;
            checkOutput($sformatf("vec%0d_cw", v),  o_codeword, vecs[v].cw);
            checkOutput($sformatf("vec%0d_dec", v), 7'(o_dec_data), 7'(vecs[v].dec));
            checkOutput($sformatf("vec%0d_syn", v), 7'(o_syndrome), 7'(vecs[v].syn));
            checkOutput($sformatf("vec%0d_err", v), 7'(o_err_flag), 7'(vecs[v].err));
        end

        // Clean pipeline before the streaming sweep
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        since     = 0;
        prev_data = '0;
        prev_pos  = '0;

        for (int i = 0; i < 128; i++) begin
            cur_data = 4'(i >> 3);
            cur_pos  = 3'(i);
            applyStimulus(cur_data, 1'b1, cur_pos);
            @(posedge i_clk);
            #1;
            checkOutput($sformatf("sw%0d_cw", i), o_codeword, cw_tab[cur_data]);
            if (since >= 1) begin
                checkOutput($sformatf("sw%0d_dec", i), 7'(o_dec_data), 7'(prev_data));
                checkOutput($sformatf("sw%0d_syn", i), 7'(o_syndrome), 7'(prev_pos));
                checkOutput($sformatf("sw%0d_err", i), 7'(o_err_flag), 7'(prev_pos != 3'd0));
            end else begin
                checkOutput($sformatf("sw%0d_dec0", i), 7'(o_dec_data), 7'h00);
                checkOutput($sformatf("sw%0d_err0", i), 7'(o_err_flag), 7'h00);
            end
            since++;
            prev_data = cur_data;
            prev_pos  = cur_pos;

            if (i == 70) begin
                // Asynchronous reset between edges must clear everything at once
                #2;
                i_rst = 1'b1;
                #1;
                checkAllZero("midrst_async");
                @(posedge i_clk);
                #1;
                checkAllZero("midrst_hold");
                @(negedge i_clk);
                i_rst = 1'b0;
                since = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
